dest_ip_filter_table_ctrl: RTL and testbench

Register-side initiator for the destination-IP filter CAM table in the router output-port lookup. It turns single software commands (read entry, write entry, clear table) into the table's rd_req/rd_ack and wr_req/wr_ack handshakes. It holds each request until the table acknowledges or a timeout expires, and returns one response per command with status. It sits between the register decoder and the filter's table read/write ports.

---
 rtl/dest_ip_filter_table_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dest_ip_filter_table_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_ip_filter_table_ctrl.sv
// Register-side initiator for the destination-IP filter table: turns read, write
// and clear commands into held table requests with timeout and one status response.
module dest_ip_filter_table_ctrl #(
  parameter int LUT_DEPTH      = 16,
  parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [LUT_DEPTH_BITS-1:0] cmd_addr,
  input  logic [31:0]               cmd_ip,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_ip,
  output logic [1:0]                rsp_status,
  output logic [15:0]               timeout_count,
  output logic [LUT_DEPTH_BITS-1:0] table_rd_addr,
  output logic                      table_rd_req,
  input  logic [31:0]               table_rd_ip,
  input  logic                      table_rd_ack,
  output logic [LUT_DEPTH_BITS-1:0] table_wr_addr,
  output logic                      table_wr_req,
  output logic [31:0]               table_wr_ip,
  input  logic                      table_wr_ack,
  output logic [2:0]                state_dbg
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_WAIT  = 3'd1;
  localparam logic [2:0] ST_WR_WAIT  = 3'd2;
  localparam logic [2:0] ST_CLR_WAIT = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  localparam logic [1:0] STS_OK  = 2'b00;
  localparam logic [1:0] STS_TMO = 2'b01;
  localparam logic [1:0] STS_BAD = 2'b10;

  localparam logic [LUT_DEPTH_BITS:0]   DEPTH_W  = (LUT_DEPTH_BITS+1)'(LUT_DEPTH);
  localparam logic [LUT_DEPTH_BITS-1:0] LAST_IDX = LUT_DEPTH_BITS'(LUT_DEPTH - 1);
  localparam logic [15:0]               TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]                state;
  logic [LUT_DEPTH_BITS-1:0] addr_q;
  logic [31:0]               ip_q;
  logic [LUT_DEPTH_BITS-1:0] clr_idx;
  logic [15:0]               wait_cnt;
  logic                      addr_ok;
  logic                      wait_expired;

  // Command handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is high only in IDLE, so at most one command
  // is in flight and every accepted command yields exactly one rsp_valid pulse.
  assign addr_ok      = ({1'b0, cmd_addr} < DEPTH_W);
  assign wait_expired = (wait_cnt == TMO_LAST);

  // Requests and their operands come straight from registers so they drop with reset.
  assign table_rd_req  = (state == ST_RD_WAIT);
  assign table_wr_req  = (state == ST_WR_WAIT) || (state == ST_CLR_WAIT);
  assign table_rd_addr = addr_q;
  assign table_wr_addr = (state == ST_CLR_WAIT) ? clr_idx : addr_q;
  assign table_wr_ip   = (state == ST_CLR_WAIT) ? 32'd0 : ip_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      addr_q        <= '0;
      ip_q          <= 32'd0;
      clr_idx       <= '0;
      wait_cnt      <= 16'd0;
      rsp_valid     <= 1'b0;
      rsp_ip        <= 32'd0;
      rsp_status    <= 2'b00;
      timeout_count <= 16'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            ip_q      <= cmd_ip;
            clr_idx   <= '0;
            wait_cnt  <= 16'd0;
            if ((cmd_op == OP_RD) && addr_ok) begin
              state <= ST_RD_WAIT;
            end else if ((cmd_op == OP_WR) && addr_ok) begin
              state <= ST_WR_WAIT;
            end else if (cmd_op == OP_CLR) begin
              state <= ST_CLR_WAIT;
            end else begin
              state      <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_ip     <= 32'd0;
              rsp_status <= STS_BAD;
            end
          end
        end
        ST_RD_WAIT: begin
          if (table_rd_ack) begin
            state      <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_ip     <= table_rd_ip;
            rsp_status <= STS_OK;
          end else if (wait_expired) begin
            state         <= ST_RESP;
            rsp_valid     <= 1'b1;
            rsp_ip        <= 32'd0;
            rsp_status    <= STS_TMO;
            timeout_count <= (timeout_count == 16'hFFFF) ? timeout_count : timeout_count + 16'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_WR_WAIT: begin
          if (table_wr_ack) begin
            state      <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_ip     <= ip_q;
            rsp_status <= STS_OK;
          end else if (wait_expired) begin
            state         <= ST_RESP;
            rsp_valid     <= 1'b1;
            rsp_ip        <= 32'd0;
            rsp_status    <= STS_TMO;
            timeout_count <= (timeout_count == 16'hFFFF) ? timeout_count : timeout_count + 16'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_CLR_WAIT: begin
          // Each acked entry restarts the wait window for the next one.
          if (table_wr_ack) begin
            wait_cnt <= 16'd0;
            if (clr_idx == LAST_IDX) begin
              state      <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_ip     <= 32'(LUT_DEPTH);
              rsp_status <= STS_OK;
            end else begin
              clr_idx <= clr_idx + 1'b1;
            end
          end else if (wait_expired) begin
            state         <= ST_RESP;
            rsp_valid     <= 1'b1;
            rsp_ip        <= 32'(clr_idx);
            rsp_status    <= STS_TMO;
            timeout_count <= (timeout_count == 16'hFFFF) ? timeout_count : timeout_count + 16'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dest_ip_filter_table_ctrl.sv
// Bench for dest_ip_filter_table_ctrl: randomized commands against a table
// responder with per-request ack delays, checked by a response scoreboard.
module tb_dest_ip_filter_table_ctrl;

  localparam int DEPTH = 12;
  localparam int ABITS = 4;
  localparam int TMO   = 8;
  localparam int W     = 67;  // {ip_chk, latency[15:0], tcount[15:0], status[1:0], ip[31:0]}

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [ABITS-1:0] cmd_addr = '0;
  logic [31:0]      cmd_ip = 32'd0;
  logic             rsp_valid;
  logic [31:0]      rsp_ip;
  logic [1:0]       rsp_status;
  logic [15:0]      timeout_count;
  logic [ABITS-1:0] table_rd_addr;
  logic             table_rd_req;
  logic [31:0]      table_rd_ip = 32'd0;
  logic             table_rd_ack = 1'b0;
  logic [ABITS-1:0] table_wr_addr;
  logic             table_wr_req;
  logic [31:0]      table_wr_ip;
  logic             table_wr_ack = 1'b0;
  logic [2:0]       state_dbg;

  dest_ip_filter_table_ctrl #(
    .LUT_DEPTH(DEPTH), .LUT_DEPTH_BITS(ABITS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_ip(cmd_ip),
    .rsp_valid(rsp_valid), .rsp_ip(rsp_ip), .rsp_status(rsp_status),
    .timeout_count(timeout_count),
    .table_rd_addr(table_rd_addr), .table_rd_req(table_rd_req),
    .table_rd_ip(table_rd_ip), .table_rd_ack(table_rd_ack),
    .table_wr_addr(table_wr_addr), .table_wr_req(table_wr_req),
    .table_wr_ip(table_wr_ip), .table_wr_ack(table_wr_ack),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [W-1:0] exp_q[$];
  int          delay_q[$];
  logic [31:0] tbl_mem[DEPTH];
  logic [31:0] model_mem[DEPTH];
  int          model_tcount = 0;
  int          acc_cyc = 0;
  int          rsp_seen = 0;
  int          exp_addr = 0;
  logic [31:0] exp_ip = 32'd0;
  int          clr_step = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- table responder ----------------
  initial begin : responder
    int hold;
    int cur;
    hold = 0;
    cur = 0;
    forever begin
      @(posedge clk);
      #1;
      table_rd_ack = 1'b0;
      table_wr_ack = 1'b0;
      table_rd_ip  = $urandom();
      if (!resetn) begin
        hold = 0;
      end else if (table_rd_req || table_wr_req) begin
        if (hold == 0) cur = (delay_q.size() > 0) ? delay_q.pop_front() : 1000;
        hold++;
        if (hold == cur) begin
          hold = 0;
          if (table_rd_req) begin
            check("rd_addr", 64'(table_rd_addr), 64'(exp_addr));
            table_rd_ip  = tbl_mem[table_rd_addr];
            table_rd_ack = 1'b1;
          end else begin
            check("wr_addr", 64'(table_wr_addr), 64'(exp_addr + clr_step));
            check("wr_ip", 64'(table_wr_ip), 64'(exp_ip));
            if (int'(table_wr_addr) < DEPTH) tbl_mem[table_wr_addr] = table_wr_ip;
            clr_step++;
            table_wr_ack = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          // wrong-type ack while a request is pending
          if (table_wr_req) table_rd_ack = 1'b1;
          else table_wr_ack = 1'b1;
        end
      end else begin
        hold = 0;
        if ($urandom_range(0, 7) == 0) begin
          table_rd_ack = 1'b1;
          table_wr_ack = 1'b1;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid with status %0h, required none", rsp_status);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_status", 64'(rsp_status), 64'(mon_e[33:32]));
        if (mon_e[66]) check("rsp_ip", 64'(rsp_ip), 64'(mon_e[31:0]));
        check("timeout_count", 64'(timeout_count), 64'(mon_e[49:34]));
        check("rsp_latency", 64'(cyc - acc_cyc), 64'(mon_e[65:50]));
        check("req_low_at_rsp", 64'({table_rd_req, table_wr_req}), 64'(0));
      end
    end
  end

  // ---------------- reference model + driver ----------------
  function automatic int rand_clr_delay();
    return ($urandom_range(0, 29) == 0) ? TMO + 1 : int'($urandom_range(1, 3));
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [ABITS-1:0] addr,
                        input logic [31:0] ip, input int fd);
    int d;
    int lat;
    int n;
    int waited;
    int target;
    logic [31:0] eip;
    logic [1:0] est;
    logic chk;
    eip = 32'd0; est = 2'b00; lat = 0; chk = 1'b1;
    exp_addr = int'(addr); exp_ip = ip; clr_step = 0;
    if (op == 2'b11 || ((op == 2'b00 || op == 2'b01) && int'(addr) >= DEPTH)) begin
      est = 2'b10;
    end else if (op == 2'b10) begin
      n = 0;
      exp_addr = 0; exp_ip = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        d = (fd > 0) ? fd : rand_clr_delay();
        delay_q.push_back(d);
        if (d > TMO) begin
          est = 2'b01; lat += TMO;
          break;
        end
        lat += d; n++;
        model_mem[i] = 32'd0;
      end
      eip = 32'(n);
    end else begin
      d = (fd > 0) ? fd : int'($urandom_range(1, TMO + 2));
      delay_q.push_back(d);
      if (d > TMO) begin
        est = 2'b01; lat = TMO; chk = 1'b0;
      end else begin
        lat = d;
        if (op == 2'b01) begin
          eip = ip; model_mem[addr] = ip;
        end else begin
          eip = model_mem[addr];
        end
      end
    end
    if (est == 2'b01 && model_tcount < 16'hFFFF) model_tcount++;
    exp_q.push_back({chk, 16'(lat), 16'(model_tcount), est, eip});

    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_ready_wait: got cmd_ready 0 after 50 cycles, required 1");
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_ip = ip;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0; cmd_op = 2'($urandom()); cmd_addr = ABITS'($urandom()); cmd_ip = $urandom();
    target = rsp_seen + 1;
    waited = 0;
    while (rsp_seen < target && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (rsp_seen < target) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_wait: got no response within 400 cycles, required one");
      exp_q.delete();
      delay_q.delete();
    end
  endtask

  task automatic reset_mid_write();
    @(negedge clk);
    while (!cmd_ready) @(negedge clk);
    delay_q.push_back(1000);
    exp_addr = 2; exp_ip = 32'hDEADBEEF; clr_step = 0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd2; cmd_ip = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wr_req_before_reset", 64'(table_wr_req), 64'(1));
    #1;
    resetn = 1'b0;
    #1;
    check("wr_req_async_drop", 64'(table_wr_req), 64'(0));
    check("state_async_idle", 64'(state_dbg), 64'(0));
    delay_q.delete();
    model_tcount = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("ready_low_after_release", 64'(cmd_ready), 64'(0));
    @(posedge clk);
    #1;
    check("ready_one_edge_after_release", 64'(cmd_ready), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int r;
    for (int i = 0; i < DEPTH; i++) begin
      tbl_mem[i] = $urandom();
      model_mem[i] = tbl_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_reqs", 64'({table_rd_req, table_wr_req}), 64'(0));
    check("rst_timeout_count", 64'(timeout_count), 64'(0));
    check("rst_rsp", 64'({rsp_status, rsp_ip}), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("ready_before_first_edge", 64'(cmd_ready), 64'(0));
    @(posedge clk);
    #1;
    check("ready_first_edge", 64'(cmd_ready), 64'(1));

    do_cmd(2'b01, 4'd3, 32'hC0A80001, 2);   // write, ack after 2
    do_cmd(2'b00, 4'd3, 32'h0, 1);          // read back
    do_cmd(2'b10, 4'd0, 32'h0, 1);          // clear, ack every cycle
    do_cmd(2'b00, 4'd3, 32'h0, 1);          // cleared entry reads 0
    do_cmd(2'b01, 4'd5, 32'h12345678, TMO + 1);  // no ack: timeout
    do_cmd(2'b01, 4'd5, 32'h12345678, TMO);      // ack on expiry cycle
    do_cmd(2'b00, 4'd5, 32'h0, TMO);
    do_cmd(2'b11, 4'd1, 32'h0, 1);          // reserved op
    do_cmd(2'b00, 4'd13, 32'h0, 1);         // address beyond table
    do_cmd(2'b01, 4'd12, 32'hFFFFFFFF, 1);
    do_cmd(2'b00, 4'd11, 32'h0, 3);         // last entry

    for (int k = 0; k < 150; k++) begin
      r = int'($urandom_range(0, 19));
      if (r < 8)       do_cmd(2'b01, ABITS'($urandom()), $urandom(), 0);
      else if (r < 15) do_cmd(2'b00, ABITS'($urandom()), $urandom(), 0);
      else if (r < 17) do_cmd(2'b10, ABITS'($urandom()), $urandom(), 0);
      else             do_cmd(2'b11, ABITS'($urandom()), $urandom(), 0);
    end

    reset_mid_write();
    for (int k = 0; k < 20; k++) begin
      do_cmd(2'($urandom_range(0, 1)), ABITS'($urandom_range(0, DEPTH - 1)), $urandom(), 0);
    end
    do_cmd(2'b10, 4'd0, 32'h0, 2);
    do_cmd(2'b00, 4'd7, 32'h0, 1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
